// File: rtl/usb_host_pkg.sv
// Shared USB host definitions: PID values, transaction type/result encodings and
// RXStatus bit positions used by the host transaction engine.
package usb_host_pkg;

  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;

  typedef enum logic [1:0] {
    TT_SETUP = 2'b00,
    TT_IN    = 2'b01,
    TT_OUT0  = 2'b10,
    TT_OUT1  = 2'b11
  } trans_type_e;

  typedef enum logic [2:0] {
    RES_OK      = 3'd0,
    RES_NAK     = 3'd1,
    RES_STALL   = 3'd2,
    RES_TIMEOUT = 3'd3,
    RES_ERROR   = 3'd4
  } trans_res_e;

  localparam int RX_SEQ   = 7;
  localparam int RX_ACK   = 6;
  localparam int RX_STALL = 5;
  localparam int RX_NAK   = 4;
  localparam int RX_TMO   = 3;

  function automatic logic [3:0] tokenPid(input trans_type_e t);
    case (t)
      TT_SETUP: tokenPid = PID_SETUP;
      TT_IN:    tokenPid = PID_IN;
      default:  tokenPid = PID_OUT;
    endcase
  endfunction

endpackage

// File: rtl/usb_host_trans_engine.sv
// Host-side USB transaction sequencer: token/data/handshake phases with bounded
// retry, optional NAK retry, receive watchdog and a latched result code.
module usb_host_trans_engine
  import usb_host_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_W   = 2,
  parameter int NAK_RETRY = 0,
  parameter int WDOG_CYC  = 4095,
  parameter int DONE_DLY  = 16,
  parameter int RETRY_GAP = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               transReq,
  input  logic [1:0]         transType,
  input  logic               isoEn,
  input  logic [7:0]         RXStatus,
  input  logic               sendPacketArbiterGnt,
  input  logic               sendPacketRdy,
  input  logic               getPacketRdy,
  output logic               sendPacketArbiterReq,
  output logic [3:0]         sendPacketPID,
  output logic               sendPacketWEn,
  output logic               getPacketREn,
  output logic               transDone,
  output logic               clearTXReq,
  output logic [2:0]         transResult,
  output logic [RETRY_W-1:0] retryCnt
);

  localparam int TMR_MAX0 = (WDOG_CYC > DONE_DLY) ? WDOG_CYC : DONE_DLY;
  localparam int TMR_MAX  = (TMR_MAX0 > RETRY_GAP) ? TMR_MAX0 : RETRY_GAP;
  localparam int TMR_W    = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_TOKEN, S_TOK_GAP, S_DATA, S_DAT_GAP, S_WAIT_RDY, S_RX,
    S_RX_WAIT, S_CHECK, S_ACK_TX, S_ACK_GAP, S_GAP, S_DONE, S_HOLD
  } state_e;

  state_e              state, stateN;
  logic [TMR_W-1:0]    tmr, tmrN;
  logic [RETRY_W-1:0]  retryN;
  trans_type_e         typeQ, typeN;
  logic                isoQ, isoN;
  logic [7:0]          rxStat, rxStatN;
  logic                arbReqN, wEnN, rEnN, doneN;
  logic [3:0]          pidN;
  logic [2:0]          resultN;
  logic                fail, goDone, canRetry;
  trans_res_e          failCode, doneCode;
  logic [TMR_W-1:0]    tmrInc;

  // Shared timer saturates instead of wrapping
  assign tmrInc = (tmr == '1) ? tmr : tmr + 1'b1;

  always_comb begin
    stateN   = state;
    tmrN     = tmr;
    retryN   = retryCnt;
    typeN    = typeQ;
    isoN     = isoQ;
    rxStatN  = rxStat;
    arbReqN  = sendPacketArbiterReq;
    pidN     = sendPacketPID;
    wEnN     = 1'b0;
    rEnN     = 1'b0;
    doneN    = 1'b0;
    resultN  = transResult;
    fail     = 1'b0;
    goDone   = 1'b0;
    failCode = RES_ERROR;
    doneCode = RES_OK;
    canRetry = 1'b0;
    case (state)
      S_IDLE: if (transReq) begin
        stateN  = S_ARB;
        arbReqN = 1'b1;
        retryN  = '0;
      end
      S_ARB: if (sendPacketArbiterGnt) begin
        stateN = S_TOKEN;
        typeN  = trans_type_e'(transType);
        isoN   = isoEn;
      end
      S_TOKEN: if (sendPacketRdy) begin
        wEnN   = 1'b1;
        pidN   = tokenPid(typeQ);
        stateN = S_TOK_GAP;
      end
      S_TOK_GAP: stateN = (typeQ == TT_IN) ? S_RX : S_DATA;
      S_DATA: if (sendPacketRdy) begin
        wEnN   = 1'b1;
        pidN   = (typeQ == TT_OUT1) ? PID_DATA1 : PID_DATA0;
        stateN = S_DAT_GAP;
      end
      S_DAT_GAP:  stateN = isoQ ? S_WAIT_RDY : S_RX;
      S_WAIT_RDY: if (sendPacketRdy) goDone = 1'b1;
      S_RX: if (sendPacketRdy) begin
        rEnN   = 1'b1;
        tmrN   = '0;
        stateN = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        // A reply landing on the expiry cycle still wins over the watchdog
        if (getPacketRdy) begin
          rxStatN = RXStatus;
          stateN  = S_CHECK;
        end else if (tmr == TMR_W'(WDOG_CYC - 1)) begin
          fail     = 1'b1;
          failCode = RES_TIMEOUT;
        end else begin
          tmrN = tmrInc;
        end
      end
      S_CHECK: begin
        if (rxStat[RX_STALL]) begin
          goDone   = 1'b1;
          doneCode = RES_STALL;
        end else if (rxStat[RX_NAK]) begin
          fail     = 1'b1;
          failCode = RES_NAK;
        end else if (|rxStat[3:0]) begin
          fail     = 1'b1;
          failCode = (rxStat[3:0] == 4'b1000) ? RES_TIMEOUT : RES_ERROR;
        end else if (typeQ == TT_IN) begin
          if (isoQ) goDone = 1'b1;
          else      stateN = S_ACK_TX;
        end else if (rxStat[RX_ACK]) begin
          goDone = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      S_ACK_TX: if (sendPacketRdy) begin
        wEnN   = 1'b1;
        pidN   = PID_ACK;
        stateN = S_ACK_GAP;
      end
      S_ACK_GAP: stateN = S_WAIT_RDY;
      S_GAP: begin
        if (tmr == TMR_W'(RETRY_GAP - 1)) stateN = S_TOKEN;
        else                              tmrN   = tmrInc;
      end
      S_DONE: begin
        stateN = S_HOLD;
        tmrN   = '0;
      end
      S_HOLD: begin
        if (tmr == TMR_W'(DONE_DLY - 1)) stateN = S_IDLE;
        else                             tmrN   = tmrInc;
      end
      default: stateN = S_IDLE;
    endcase

    canRetry = (int'(retryCnt) < MAX_RETRY) && (failCode != RES_NAK || NAK_RETRY != 0) && !isoQ;
    if (fail) begin
      if (canRetry) begin
        retryN = retryCnt + 1'b1;
        tmrN   = '0;
        stateN = S_GAP;
      end else begin
        goDone   = 1'b1;
        doneCode = failCode;
      end
    end

    if (goDone) begin
      stateN  = S_DONE;
      doneN   = 1'b1;
      arbReqN = 1'b0;
      resultN = doneCode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      tmr                  <= '0;
      retryCnt             <= '0;
      typeQ                <= TT_SETUP;
      isoQ                 <= 1'b0;
      rxStat               <= '0;
      sendPacketArbiterReq <= 1'b0;
      sendPacketPID        <= '0;
      sendPacketWEn        <= 1'b0;
      getPacketREn         <= 1'b0;
      transDone            <= 1'b0;
      clearTXReq           <= 1'b0;
      transResult          <= '0;
    end else begin
      state                <= stateN;
      tmr                  <= tmrN;
      retryCnt             <= retryN;
      typeQ                <= typeN;
      isoQ                 <= isoN;
      rxStat               <= rxStatN;
      sendPacketArbiterReq <= arbReqN;
      sendPacketPID        <= pidN;
      sendPacketWEn        <= wEnN;
      getPacketREn         <= rEnN;
      transDone            <= doneN;
      clearTXReq           <= doneN;
      transResult          <= resultN;
    end
  end

endmodule
